// File: rtl/alu_serial_seq_if.sv
// Request/response bundle between a client and the bit-serial ALU sequencer.
// Request side: in_valid/in_ready with opcode and operands.
// Response side: out_valid/out_ready with result, carry and zero flags.
interface alu_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;

  // Client side: issues requests, consumes results.
  modport master (
    output in_valid, opcode, a_in, b_in, out_ready,
    input  in_ready, out_valid, result, carry, zero
  );

  // Sequencer side: accepts requests, produces results.
  modport slave (
    input  in_valid, opcode, a_in, b_in, out_ready,
    output in_ready, out_valid, result, carry, zero
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one 1-bit slice evaluates WIDTH bits LSB first.
// Latency: out_valid rises WIDTH edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; no new request accepted until back in IDLE.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  alu_serial_seq_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Slice control bits packed as {op0, op1, op2, op3, op4}:
  // op0/op1 invert A/B, op2 masks carry-in from o, op3 masks the OR term, op4 masks the AND term.
  function automatic logic [4:0] op_ctl(input logic [2:0] op);
    case (op)
      3'b000:  op_ctl = 5'b00000; // ADD
      3'b001:  op_ctl = 5'b01000; // SUB
      3'b010:  op_ctl = 5'b00110; // AND
      3'b011:  op_ctl = 5'b00101; // OR
      3'b100:  op_ctl = 5'b00100; // XOR
      3'b101:  op_ctl = 5'b11101; // NAND
      3'b110:  op_ctl = 5'b11110; // NOR
      default: op_ctl = 5'b10100; // XNOR
    endcase
  endfunction

  // SUB starts with carry-in 1 so that a + ~b + 1 gives a - b.
  function automatic logic op_cin(input logic [2:0] op);
    op_cin = (op == 3'b001);
  endfunction

  function automatic logic op_arith(input logic [2:0] op);
    op_arith = (op == 3'b000) || (op == 3'b001);
  endfunction

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             cin_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             zero_q;

  logic             accept;
  logic             in_ready;
  logic             out_valid;
  logic             last_bit;

  logic [4:0]       ctl;
  logic             sa;
  logic             sb;
  logic             s_o;
  logic             s_cout;
  logic [WIDTH-1:0] res_nxt;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // One ALU slice on the current bit, plus the result word with that bit replaced.
  always_comb begin
    ctl     = op_ctl(op_q);
    sa      = a_q[cnt] ^ ctl[4];
    sb      = b_q[cnt] ^ ctl[3];
    s_cout  = (sa & sb) | (sa & cin_q) | (sb & cin_q);
    s_o     = (sa & sb & ~ctl[0]) ^ ((sa | sb) & ~ctl[1]) ^ (cin_q & ~ctl[2]);
    res_nxt = res_q;
    res_nxt[cnt] = s_o;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs; requests only accepted in IDLE.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, bit counter, carry register and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt     <= '0;
      cin_q   <= 1'b0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a_in;
      b_q   <= bus.b_in;
      op_q  <= bus.opcode;
      cin_q <= op_cin(bus.opcode);
      cnt   <= '0;
    end else if (state == RUN) begin
      res_q <= res_nxt;
      cin_q <= s_cout;
      if (last_bit) begin
        // All bits of res_nxt belong to this operation once the top bit is written.
        carry_q <= op_arith(op_q) ? s_cout : 1'b0;
        zero_q  <= (res_nxt == '0);
        cnt     <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.result    = res_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq: directed cases plus random traffic
// against an arithmetic reference model, with latency, backpressure and reset checks.
module tb_alu_serial_seq;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {carry, result} from plain arithmetic on the operands.
  function automatic logic [W:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {(a >= b) ? 1'b1 : 1'b0, a - b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b0, ~(a & b)};
      3'd6: r = {1'b0, ~(a | b)};
      default: r = {1'b0, ~(a ^ b)};
    endcase
    return r;
  endfunction

  // Issue one request (called #1 after an edge with the DUT idle), check the
  // response, optionally stall out_ready for 'hold' cycles while offering a
  // second request, then complete the output handshake.
  task automatic run_txn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input string tag);
    logic [W:0]   exp;
    logic [W-1:0] r0;
    logic         c0;
    logic         z0;
    logic         busy_ok;
    logic         hold_ok;
    int           lat;
    exp = ref_alu(op, a, b);
    chk({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.a_in      = a;
    bus.b_in      = b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    // Inputs are free to change after the accept edge.
    bus.in_valid = 1'b0;
    bus.opcode   = 3'($urandom);
    bus.a_in     = W'($urandom);
    bus.b_in     = W'($urandom);
    lat     = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 3 * W) begin
      if (bus.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(W));
    chk({tag, " in_ready low while busy"}, 32'(busy_ok), 32'd1);
    chk({tag, " result"}, 32'(bus.result), 32'(exp[W-1:0]));
    chk({tag, " carry"}, 32'(bus.carry), 32'(exp[W]));
    chk({tag, " zero"}, 32'(bus.zero), 32'(exp[W-1:0] == '0));
    r0 = bus.result;
    c0 = bus.carry;
    z0 = bus.zero;
    hold_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = 3'($urandom);
      bus.a_in     = W'($urandom);
      bus.b_in     = W'($urandom);
      @(posedge clk); #1;
      if (!bus.out_valid || bus.in_ready || bus.result !== r0 || bus.carry !== c0 || bus.zero !== z0)
        hold_ok = 1'b0;
    end
    if (hold > 0) chk({tag, " stable under backpressure"}, 32'(hold_ok), 32'd1);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic quiet;
    bus.in_valid  = 1'b0;
    bus.opcode    = 3'd0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b0;

    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset carry", 32'(bus.carry), 32'd0);
    chk("reset zero", 32'(bus.zero), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    run_txn(3'd0, 8'hFF, 8'h01, 0, "add ff+01");
    run_txn(3'd1, 8'h05, 8'h07, 0, "sub 05-07");
    run_txn(3'd1, 8'h07, 8'h05, 0, "sub 07-05");
    run_txn(3'd2, 8'hF0, 8'h3C, 0, "and");
    run_txn(3'd3, 8'hF0, 8'h3C, 0, "or");
    run_txn(3'd4, 8'hF0, 8'h3C, 0, "xor");
    run_txn(3'd5, 8'hF0, 8'h3C, 0, "nand");
    run_txn(3'd6, 8'hF0, 8'h3C, 0, "nor");
    run_txn(3'd7, 8'hF0, 8'h3C, 0, "xnor");

    // Backpressure with a competing request, then the next request right after release.
    run_txn(3'd0, 8'h21, 8'h43, 5, "bp first");
    run_txn(3'd1, 8'h80, 8'h01, 0, "bp second");

    // Reset while bit 4 of an ADD is pending.
    bus.in_valid = 1'b1;
    bus.opcode   = 3'd0;
    bus.a_in     = 8'h12;
    bus.b_in     = 8'h34;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrun rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrun rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrun rst result", 32'(bus.result), 32'd0);
    chk("midrun rst carry", 32'(bus.carry), 32'd0);
    chk("midrun rst zero", 32'(bus.zero), 32'd0);
    @(negedge clk) rst = 1'b0;
    quiet = 1'b1;
    repeat (2 * W) begin
      @(posedge clk); #1;
      if (bus.out_valid) quiet = 1'b0;
    end
    chk("no output after rst", 32'(quiet), 32'd1);
    run_txn(3'd0, 8'h12, 8'h34, 0, "add after rst");

    for (int t = 0; t < 1000; t++) begin
      run_txn(3'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)), "rand");
    end
    bus.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
